// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin encoder arbiter.
package arb_pkg;

    localparam int NREQ = 8;
    localparam int IDXW = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } state_t;

endpackage

// File: rtl/onehot_enc8.sv
// 8-bit one-hot to 3-bit binary encoder; an all-zero input encodes to 0.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx
);

    assign idx[0] = onehot[1] | onehot[3] | onehot[5] | onehot[7];
    assign idx[1] = onehot[2] | onehot[3] | onehot[6] | onehot[7];
    assign idx[2] = onehot[4] | onehot[5] | onehot[6] | onehot[7];

endmodule

// File: rtl/rr_enc_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// encoded winner index, done-based release and hold-timeout preemption.
module rr_enc_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [HCW-1:0]  hold_cnt;

    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] cand;
    logic            found;
    logic [NREQ-1:0] pick_onehot;
    logic            expiry;
    logic            abandon;
    logic            release_now;

    // Scan requesters starting at ptr and wrapping; first set bit wins.
    always_comb begin
        pick  = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + IDXW'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        pick_onehot = NREQ'(1) << pick;
    end

    assign expiry      = (MAX_HOLD > 0) && (hold_cnt == HCW'(MAX_HOLD - 1));
    assign abandon     = ((req & gnt) == '0);
    assign release_now = done || abandon || expiry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
        end else begin
            case (state)
                IDLE, RECOVER: begin
                    if (|req) begin
                        gnt      <= pick_onehot;
                        ptr      <= pick + IDXW'(1);
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end else begin
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt   <= '0;
                        state <= RECOVER;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Timeout must flag the expiring cycle itself and yield to a same-cycle
    // done, so it is decoded from registered state rather than registered.
    assign timeout = rst_n && (state == GRANT) && expiry && !done;

    assign gnt_valid = |gnt;

    onehot_enc8 u_enc (
        .onehot (gnt),
        .idx    (gnt_idx)
    );

endmodule

// File: tb/tb_rr_enc_arbiter.sv
// Scoreboard bench for rr_enc_arbiter: per-cycle stimulus rows carry the
// expected outputs, which are queued when driven and compared after settling.
module tb_rr_enc_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic       to;
    } row_t;

    row_t stim[$];
    row_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    rr_enc_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic add(input logic r, input logic [7:0] q, input logic d,
                       input logic [7:0] g, input logic t);
        row_t x;
        x.rst_n = r; x.req = q; x.done = d; x.gnt = g; x.to = t;
        stim.push_back(x);
    endtask

    task automatic test_reset();
        row_t r, e;
        add(0, 8'hFF, 0, 8'h00, 0);
        add(0, 8'hFF, 1, 8'h00, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        while (stim.size() > 0) begin
            r = stim.pop_front();
            rst_n = r.rst_n; req = r.req; done = r.done;
            sb.push_back(r);
            #1;
            e = sb.pop_front();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to}) begin
                bad++;
                $display("[TB] FAIL reset cyc%0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                         cyc, gnt, gnt_idx, gnt_valid, timeout, e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        row_t r, e;
        add(1, 8'h04, 0, 8'h00, 0);
        add(1, 8'h04, 1, 8'h04, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        add(1, 8'h00, 1, 8'h00, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        while (stim.size() > 0) begin
            r = stim.pop_front();
            rst_n = r.rst_n; req = r.req; done = r.done;
            sb.push_back(r);
            #1;
            e = sb.pop_front();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to}) begin
                bad++;
                $display("[TB] FAIL single cyc%0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                         cyc, gnt, gnt_idx, gnt_valid, timeout, e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fairness();
        row_t r, e;
        add(0, 8'hFF, 0, 8'h00, 0);
        add(1, 8'hFF, 0, 8'h00, 0);
        for (int k = 0; k < 9; k++) begin
            add(1, 8'hFF, 1, 8'(1 << (k % 8)), 0);
            add(1, (k == 8) ? 8'h00 : 8'hFF, 0, 8'h00, 0);
        end
        add(1, 8'h00, 0, 8'h00, 0);
        while (stim.size() > 0) begin
            r = stim.pop_front();
            rst_n = r.rst_n; req = r.req; done = r.done;
            sb.push_back(r);
            #1;
            e = sb.pop_front();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to}) begin
                bad++;
                $display("[TB] FAIL fairness cyc%0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                         cyc, gnt, gnt_idx, gnt_valid, timeout, e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        row_t r, e;
        add(0, 8'h00, 0, 8'h00, 0);
        add(1, 8'h80, 0, 8'h00, 0);
        add(1, 8'h80, 1, 8'h80, 0);
        add(1, 8'h81, 0, 8'h00, 0);
        add(1, 8'h81, 1, 8'h01, 0);
        add(1, 8'h81, 0, 8'h00, 0);
        add(1, 8'h00, 1, 8'h80, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        while (stim.size() > 0) begin
            r = stim.pop_front();
            rst_n = r.rst_n; req = r.req; done = r.done;
            sb.push_back(r);
            #1;
            e = sb.pop_front();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to}) begin
                bad++;
                $display("[TB] FAIL wrap cyc%0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                         cyc, gnt, gnt_idx, gnt_valid, timeout, e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        row_t r, e;
        add(1, 8'h02, 0, 8'h00, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(1, 8'h02, 0, 8'h02, 1);
        add(1, 8'h02, 0, 8'h00, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(1, 8'h02, 1, 8'h02, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        while (stim.size() > 0) begin
            r = stim.pop_front();
            rst_n = r.rst_n; req = r.req; done = r.done;
            sb.push_back(r);
            #1;
            e = sb.pop_front();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to}) begin
                bad++;
                $display("[TB] FAIL timeout cyc%0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                         cyc, gnt, gnt_idx, gnt_valid, timeout, e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abandon_reset();
        row_t r, e;
        // ptr is 2 here; req[3] alone wins, then is dropped mid-grant
        add(1, 8'h08, 0, 8'h00, 0);
        add(1, 8'h08, 0, 8'h08, 0);
        add(1, 8'h00, 0, 8'h08, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        add(1, 8'hFF, 0, 8'h00, 0);
        add(1, 8'hFF, 0, 8'h10, 0);
        add(0, 8'hFF, 0, 8'h10, 0);
        add(1, 8'hFF, 0, 8'h00, 0);
        add(1, 8'hFF, 1, 8'h01, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        add(1, 8'h02, 0, 8'h00, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(1, 8'h02, 0, 8'h02, 0);
        add(0, 8'h02, 0, 8'h02, 0);
        add(1, 8'h00, 0, 8'h00, 0);
        while (stim.size() > 0) begin
            r = stim.pop_front();
            rst_n = r.rst_n; req = r.req; done = r.done;
            sb.push_back(r);
            #1;
            e = sb.pop_front();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to}) begin
                bad++;
                $display("[TB] FAIL abandon_reset cyc%0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                         cyc, gnt, gnt_idx, gnt_valid, timeout, e.gnt, ref_idx(e.gnt), (e.gnt != 8'h00), e.to);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_abandon_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
